// File: rtl/seg_display_sched.sv
// seg_display_sched: round-robin owner of the 3-digit display.
// Captures one source per dwell and converts it to BCD.
module seg_display_sched #(
  parameter int NUM_SRC    = 4,
  parameter int TICK_DIV   = 50000,
  parameter int HOLD_TICKS = 1000,
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic [NUM_SRC*10-1:0] src_number,
  input  logic                  freeze,
  output logic [NUM_SRC-1:0]    src_ack,
  output logic [11:0]           bcd,
  output logic [SW-1:0]         src_sel,
  output logic                  overflow,
  output logic                  disp_valid,
  output logic                  busy
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    CONVERT,
    SHOW
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [PW-1:0] pre;
  logic [HW-1:0] dwell;
  logic          tick;
  logic          dwell_done;
  logic [SW-1:0] ptr;
  logic [SW-1:0] pick;
  logic [SW-1:0] idx;
  logic          found;
  logic [9:0]    nums [NUM_SRC];
  logic [9:0]    pick_val;
  logic [9:0]    clamp;
  logic [3:0]    cnt;
  logic [21:0]   sh;

  // One double-dabble iteration: adjust nibbles, then shift left.
  function automatic logic [21:0] dd_step(input logic [21:0] s);
    logic [21:0] t;
    t = s;
    for (int n = 0; n < 3; n++) begin
      if (t[10+4*n +: 4] >= 4'd5)
        t[10+4*n +: 4] = t[10+4*n +: 4] + 4'd3;
    end
    return {t[20:0], 1'b0};
  endfunction

  assign tick       = (pre == PW'(TICK_DIV - 1));
  assign dwell_done = tick && !freeze &&
                      (dwell == HW'(HOLD_TICKS - 1));
  assign busy       = (state == SELECT) || (state == CONVERT);

  // Free-running prescaler producing the dwell tick.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pre <= '0;
    else if (tick) pre <= '0;
    else pre <= pre + PW'(1);
  end

  // Round-robin scan starting at the priority pointer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = SW'((int'(ptr) + k) % NUM_SRC);
      if (!found && src_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Unpack source values and clamp the chosen one.
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++)
      nums[k] = src_number[10*k +: 10];
    pick_val = nums[pick];
    clamp    = (pick_val > 10'd999) ? 10'd999 : pick_val;
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else state <= nxt;
  end

  // Next-state decode.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (|src_valid) nxt = SELECT;
      SELECT:  nxt = found ? CONVERT : IDLE;
      CONVERT: if (cnt == 4'd10) nxt = SHOW;
      SHOW:    if (dwell_done) nxt = SELECT;
      default: nxt = IDLE;
    endcase
  end

  // Capture, conversion, dwell counting and display registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      src_ack    <= '0;
      bcd        <= '0;
      src_sel    <= '0;
      overflow   <= 1'b0;
      disp_valid <= 1'b0;
      ptr        <= '0;
      dwell      <= '0;
      cnt        <= '0;
      sh         <= '0;
    end else begin
      src_ack <= '0;
      unique case (state)
        SELECT: begin
          if (found) begin
            src_ack  <= NUM_SRC'(1) << pick;
            src_sel  <= pick;
            ptr      <= (pick == SW'(NUM_SRC - 1)) ?
                        '0 : pick + SW'(1);
            overflow <= (pick_val > 10'd999);
            sh       <= {12'd0, clamp};
            cnt      <= '0;
          end else begin
            disp_valid <= 1'b0;
          end
        end
        CONVERT: begin
          if (cnt == 4'd10) begin
            bcd        <= sh[21:10];
            disp_valid <= 1'b1;
          end else begin
            sh  <= dd_step(sh);
            cnt <= cnt + 4'd1;
          end
        end
        SHOW: begin
          if (tick && !freeze)
            dwell <= dwell_done ? '0 : dwell + HW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_sched.sv
// tb_seg_display_sched: directed checks of source rotation,
// BCD conversion, clamping, freeze, idle return and reset.
module tb_seg_display_sched;

  logic        CLK;
  logic        RST;
  logic [3:0]  src_valid;
  logic [39:0] src_number;
  logic        freeze;
  logic [3:0]  src_ack;
  logic [11:0] bcd;
  logic [1:0]  src_sel;
  logic        overflow;
  logic        disp_valid;
  logic        busy;

  logic [9:0]  num [4];
  int          checks;
  int          errors;
  int          n;
  int          acks;

  assign src_number = {num[3], num[2], num[1], num[0]};

  seg_display_sched #(
    .NUM_SRC(4),
    .TICK_DIV(4),
    .HOLD_TICKS(3)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .src_valid(src_valid),
    .src_number(src_number),
    .freeze(freeze),
    .src_ack(src_ack),
    .bcd(bcd),
    .src_sel(src_sel),
    .overflow(overflow),
    .disp_valid(disp_valid),
    .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic capture(input string tag,
                         input logic [3:0] ack_e,
                         input logic [11:0] bcd_e,
                         input logic ovf_e,
                         input logic [1:0] sel_e,
                         input logic [11:0] old_e,
                         output int wait_n);
    wait_n = 0;
    while (src_ack == 4'd0 && wait_n < 100) begin
      step();
      wait_n++;
    end
    check({tag, "_ack"}, src_ack, ack_e);
    check({tag, "_sel"}, src_sel, sel_e);
    check({tag, "_busy"}, busy, 1);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) check({tag, "_ack_pulse"}, src_ack, 0);
    end
    check({tag, "_old_bcd"}, bcd, old_e);
    step();
    check({tag, "_bcd"}, bcd, bcd_e);
    check({tag, "_dv"}, disp_valid, 1);
    check({tag, "_ovf"}, overflow, ovf_e);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    RST       = 1'b1;
    src_valid = 4'b0000;
    freeze    = 1'b0;
    num[0]    = 10'd123;
    num[1]    = 10'd1000;
    num[2]    = 10'd845;
    num[3]    = 10'd42;
    repeat (3) step();
    check("rst_bcd", bcd, 0);
    check("rst_sel", src_sel, 0);
    check("rst_ack", src_ack, 0);
    check("rst_ovf", overflow, 0);
    check("rst_dv", disp_valid, 0);
    check("rst_busy", busy, 0);

    src_valid = 4'b0001;
    RST = 1'b0;
    capture("first", 4'b0001, 12'h123, 1'b0, 2'd0, 12'h000, n);
    check("first_lat", n, 2);

    num[0] = 10'd7;
    src_valid = 4'b0101;
    capture("alt0", 4'b0100, 12'h845, 1'b0, 2'd2, 12'h123, n);
    check("alt0_dwell", (n >= 10 && n <= 13) ? 1 : 0, 1);
    capture("alt1", 4'b0001, 12'h007, 1'b0, 2'd0, 12'h845, n);
    check("alt1_dwell", (n >= 10 && n <= 13) ? 1 : 0, 1);
    capture("alt2", 4'b0100, 12'h845, 1'b0, 2'd2, 12'h007, n);
    capture("alt3", 4'b0001, 12'h007, 1'b0, 2'd0, 12'h845, n);

    src_valid = 4'b0010;
    capture("ovf", 4'b0010, 12'h999, 1'b1, 2'd1, 12'h007, n);
    num[1] = 10'd0;
    capture("zero", 4'b0010, 12'h000, 1'b0, 2'd1, 12'h999, n);

    repeat (5) step();
    freeze = 1'b1;
    acks = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (src_ack != 4'd0) acks++;
    end
    check("frz_acks", acks, 0);
    check("frz_sel", src_sel, 1);
    freeze = 1'b0;
    capture("frz_rel", 4'b0010, 12'h000, 1'b0, 2'd1, 12'h000, n);
    check("frz_resume", (n >= 1 && n <= 9) ? 1 : 0, 1);

    src_valid = 4'b0000;
    acks = 0;
    n = 0;
    while (disp_valid && n < 40) begin
      step();
      n++;
      if (src_ack != 4'd0) acks++;
    end
    check("drop_dv", disp_valid, 0);
    check("drop_busy", busy, 0);
    check("drop_acks", acks, 0);
    check("drop_bcd", bcd, 12'h000);

    src_valid = 4'b1000;
    capture("src3", 4'b1000, 12'h042, 1'b0, 2'd3, 12'h000, n);

    num[3] = 10'd999;
    n = 0;
    while (src_ack == 4'd0 && n < 100) begin
      step();
      n++;
    end
    check("mid_ack", src_ack, 4'b1000);
    repeat (5) step();
    check("mid_busy", busy, 1);
    RST = 1'b1;
    #1;
    check("mid_bcd", bcd, 0);
    check("mid_sel", src_sel, 0);
    check("mid_ovf", overflow, 0);
    check("mid_dv", disp_valid, 0);
    check("mid_rbusy", busy, 0);
    check("mid_rack", src_ack, 0);
    num[0] = 10'd123;
    src_valid = 4'b1001;
    repeat (2) step();
    check("mid_hold_bcd", bcd, 0);
    RST = 1'b0;
    capture("post0", 4'b0001, 12'h123, 1'b0, 2'd0, 12'h000, n);
    check("post0_lat", n, 2);
    capture("post3", 4'b1000, 12'h999, 1'b0, 2'd3, 12'h123, n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
